stage3_fence_sequencer: RTL and testbench

// Sequences FENCE.I and SFENCE.VMA maintenance for the stage3 pipeline. Sits beside the mem stage
// and drives the cache_control_if flush/fence strobes. Orders the operations: D$ writeback,

---
 rtl/stage3_fence_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_stage3_fence_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage3_fence_sequencer.sv
// Sequences FENCE.I / SFENCE.VMA maintenance beside the mem stage: D$ writeback, then I$
// invalidate, then I/D TLB fences, holding the pipeline stalled until every phase ends.
module stage3_fence_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          AT_ENABLED     = 1'b1,
  parameter int unsigned ASID_W         = 9
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              fence_i_req_i,
  input  logic              sfence_req_i,
  input  logic              mem_advance_i,
  input  logic [ASID_W-1:0] sfence_asid_i,
  input  logic [31:0]       sfence_va_i,
  input  logic              dflush_done_i,
  input  logic              iflush_done_i,
  input  logic              itlb_done_i,
  input  logic              dtlb_done_i,
  output logic              dcache_flush_o,
  output logic              icache_flush_o,
  output logic              itlb_fence_o,
  output logic              dtlb_fence_o,
  output logic [ASID_W-1:0] fence_asid_o,
  output logic [31:0]       fence_va_o,
  output logic              fence_stall_o,
  output logic              fence_done_o,
  output logic              fence_timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DFLUSH,
    S_IFLUSH,
    S_TLB,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic              need_i_q, need_i_d;
  logic              need_t_q, need_t_d;
  logic              entry_q, entry_d;
  logic              itlb_seen_q, itlb_seen_d;
  logic              dtlb_seen_q, dtlb_seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ASID_W-1:0] asid_q, asid_d;
  logic [31:0]       va_q, va_d;

  logic any_req;
  logic accept;
  logic in_phase;
  logic waiting;
  logic expired;
  logic itlb_hit;
  logic dtlb_hit;

  assign any_req  = fence_i_req_i | sfence_req_i;
  assign accept   = (state_q == S_IDLE) & armed_q & any_req;
  assign in_phase = (state_q == S_DFLUSH) | (state_q == S_IFLUSH) | (state_q == S_TLB);
  // The strobe goes out in the entry cycle; done pulses only count from the following cycle.
  assign waiting  = in_phase & ~entry_q;
  assign expired  = waiting & (cnt_q == CNT_LAST);
  assign itlb_hit = itlb_seen_q | (waiting & itlb_done_i);
  assign dtlb_hit = dtlb_seen_q | (waiting & dtlb_done_i);

  assign fence_stall_o = accept | in_phase;
  assign fence_asid_o  = asid_q;
  assign fence_va_o    = va_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    need_i_d        = need_i_q;
    need_t_d        = need_t_q;
    itlb_seen_d     = itlb_seen_q;
    dtlb_seen_d     = dtlb_seen_q;
    asid_d          = asid_q;
    va_d            = va_q;
    dcache_flush_o  = 1'b0;
    icache_flush_o  = 1'b0;
    itlb_fence_o    = 1'b0;
    dtlb_fence_o    = 1'b0;
    fence_done_o    = 1'b0;
    fence_timeout_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          need_i_d = fence_i_req_i;
          need_t_d = sfence_req_i & AT_ENABLED;
          asid_d   = sfence_asid_i;
          va_d     = sfence_va_i;
          if (fence_i_req_i)                   state_d = S_DFLUSH;
          else if (sfence_req_i & AT_ENABLED)  state_d = S_TLB;
          else                                 state_d = S_DONE;
        end
      end
      S_DFLUSH: begin
        dcache_flush_o = entry_q;
        if (waiting & dflush_done_i) begin
          state_d = S_IFLUSH;
        end else if (expired) begin
          fence_timeout_o = 1'b1;
          state_d         = S_IFLUSH;
        end
      end
      S_IFLUSH: begin
        icache_flush_o = entry_q;
        if ((waiting & iflush_done_i) | expired) begin
          fence_timeout_o = expired & ~iflush_done_i;
          state_d         = need_t_q ? S_TLB : S_DONE;
        end
      end
      S_TLB: begin
        itlb_fence_o = entry_q;
        dtlb_fence_o = entry_q;
        itlb_seen_d  = itlb_hit;
        dtlb_seen_d  = dtlb_hit;
        if (itlb_hit & dtlb_hit) begin
          state_d = S_DONE;
        end else if (expired) begin
          fence_timeout_o = 1'b1;
          state_d         = S_DONE;
        end
      end
      S_DONE: begin
        fence_done_o = 1'b1;
        need_i_d     = 1'b0;
        need_t_d     = 1'b0;
        itlb_seen_d  = 1'b0;
        dtlb_seen_d  = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter restarts on every state change and saturates at the abandon point.
  always_comb begin
    entry_d = (state_d != state_q);
    cnt_d   = cnt_q;
    if (entry_d)                             cnt_d = '0;
    else if (in_phase && cnt_q != CNT_LAST)  cnt_d = cnt_q + 1'b1;
  end

  // A fence held in the mem stage by our own stall must not be accepted twice.
  always_comb begin
    armed_d = armed_q;
    if (mem_advance_i | ~any_req) armed_d = 1'b1;
    if (accept)                   armed_d = 1'b0;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b1;
      need_i_q    <= 1'b0;
      need_t_q    <= 1'b0;
      entry_q     <= 1'b0;
      itlb_seen_q <= 1'b0;
      dtlb_seen_q <= 1'b0;
      cnt_q       <= '0;
      asid_q      <= '0;
      va_q        <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      need_i_q    <= need_i_d;
      need_t_q    <= need_t_d;
      entry_q     <= entry_d;
      itlb_seen_q <= itlb_seen_d;
      dtlb_seen_q <= dtlb_seen_d;
      cnt_q       <= cnt_d;
      asid_q      <= asid_d;
      va_q        <= va_d;
    end
  end

endmodule

// File: tb/tb_stage3_fence_sequencer.sv
// Scoreboard bench for stage3_fence_sequencer: stimulus queues expected strobe/done/timeout
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_stage3_fence_sequencer;

  localparam logic [5:0] EV_DC  = 6'b100000;
  localparam logic [5:0] EV_IC  = 6'b010000;
  localparam logic [5:0] EV_TLB = 6'b001100;
  localparam logic [5:0] EV_DN  = 6'b000010;
  localparam logic [5:0] EV_TO  = 6'b000001;

  typedef struct {
    int          cyc;
    logic [5:0]  ev;
    logic        stall;
    logic        tag;
    logic [8:0]  asid;
    logic [31:0] va;
  } exp_t;

  logic        CLK, nRST;
  logic        fence_i_req, sfence_req, mem_advance;
  logic [8:0]  sfence_asid;
  logic [31:0] sfence_va;
  logic        dflush_done, iflush_done, itlb_done, dtlb_done;
  logic        dcache_flush, icache_flush, itlb_fence, dtlb_fence;
  logic [8:0]  fence_asid;
  logic [31:0] fence_va;
  logic        fence_stall, fence_done, fence_timeout;

  logic        fence_i_req_b, sfence_req_b, mem_advance_b;
  logic        dcache_flush_b, icache_flush_b, itlb_fence_b, dtlb_fence_b;
  logic [8:0]  fence_asid_b;
  logic [31:0] fence_va_b;
  logic        fence_stall_b, fence_done_b, fence_timeout_b;

  int   cyc = 0;
  int   dd_at = -1, id_at = -1, it_at = -1, dt_at = -1;
  int   checks = 0, errors = 0;
  exp_t sb_q[$];
  exp_t e;
  logic [5:0] ev;
  int   t;

  stage3_fence_sequencer #(.TIMEOUT_CYCLES(16), .AT_ENABLED(1'b1), .ASID_W(9)) dut (
    .CLK(CLK), .nRST(nRST),
    .fence_i_req_i(fence_i_req), .sfence_req_i(sfence_req), .mem_advance_i(mem_advance),
    .sfence_asid_i(sfence_asid), .sfence_va_i(sfence_va),
    .dflush_done_i(dflush_done), .iflush_done_i(iflush_done),
    .itlb_done_i(itlb_done), .dtlb_done_i(dtlb_done),
    .dcache_flush_o(dcache_flush), .icache_flush_o(icache_flush),
    .itlb_fence_o(itlb_fence), .dtlb_fence_o(dtlb_fence),
    .fence_asid_o(fence_asid), .fence_va_o(fence_va),
    .fence_stall_o(fence_stall), .fence_done_o(fence_done), .fence_timeout_o(fence_timeout)
  );

  stage3_fence_sequencer #(.TIMEOUT_CYCLES(16), .AT_ENABLED(1'b0), .ASID_W(9)) dut_noat (
    .CLK(CLK), .nRST(nRST),
    .fence_i_req_i(fence_i_req_b), .sfence_req_i(sfence_req_b), .mem_advance_i(mem_advance_b),
    .sfence_asid_i(sfence_asid), .sfence_va_i(sfence_va),
    .dflush_done_i(dflush_done), .iflush_done_i(iflush_done),
    .itlb_done_i(itlb_done), .dtlb_done_i(dtlb_done),
    .dcache_flush_o(dcache_flush_b), .icache_flush_o(icache_flush_b),
    .itlb_fence_o(itlb_fence_b), .dtlb_fence_o(dtlb_fence_b),
    .fence_asid_o(fence_asid_b), .fence_va_o(fence_va_b),
    .fence_stall_o(fence_stall_b), .fence_done_o(fence_done_b), .fence_timeout_o(fence_timeout_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Done pulses are scheduled by absolute cycle number.
  always @(posedge CLK) begin
    #2;
    dflush_done = (cyc == dd_at);
    iflush_done = (cyc == id_at);
    itlb_done   = (cyc == it_at);
    dtlb_done   = (cyc == dt_at);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int c, input logic [5:0] evv, input logic st,
                                  input logic tg, input logic [8:0] a, input logic [31:0] v);
    exp_t x;
    x.cyc = c; x.ev = evv; x.stall = st; x.tag = tg; x.asid = a; x.va = v;
    sb_q.push_back(x);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic release_mem();
    fence_i_req = 1'b0;
    sfence_req  = 1'b0;
    mem_advance = 1'b1;
    step();
    mem_advance = 1'b0;
    step();
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      ev = {dcache_flush, icache_flush, itlb_fence, dtlb_fence, fence_done, fence_timeout};
      if (ev != 6'b0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event", {58'b0, ev}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("ev_cycle", 64'(cyc), 64'(e.cyc));
          check("ev_strobes", {58'b0, ev}, {58'b0, e.ev});
          check("ev_stall", {63'b0, fence_stall}, {63'b0, e.stall});
          if (e.tag) begin
            check("ev_asid", {55'b0, fence_asid}, {55'b0, e.asid});
            check("ev_va", {32'b0, fence_va}, {32'b0, e.va});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    fence_i_req = 1'b0; sfence_req = 1'b0; mem_advance = 1'b0;
    fence_i_req_b = 1'b0; sfence_req_b = 1'b0; mem_advance_b = 1'b0;
    sfence_asid = '0; sfence_va = '0;
    dflush_done = 1'b0; iflush_done = 1'b0; itlb_done = 1'b0; dtlb_done = 1'b0;

    // Reset state
    @(negedge CLK);
    check("rst_outputs", {21'b0, fence_stall, dcache_flush, icache_flush, itlb_fence,
          dtlb_fence, fence_done, fence_timeout, fence_asid, fence_va}, 64'd0);
    check("rst_outputs_noat", {57'b0, fence_stall_b, dcache_flush_b, icache_flush_b,
          itlb_fence_b, dtlb_fence_b, fence_done_b, fence_timeout_b}, 64'd0);
    step();
    nRST = 1'b1;
    step();

    // FENCE.I: dflush_done 3 after strobe, iflush_done 2 after; request held through DONE
    t = cyc;
    fence_i_req = 1'b1;
    dd_at = t + 4; id_at = t + 7;
    push_ev(t + 1, EV_DC, 1'b1, 1'b0, '0, '0);
    push_ev(t + 5, EV_IC, 1'b1, 1'b0, '0, '0);
    push_ev(t + 8, EV_DN, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k <= 11; k++) begin
      @(negedge CLK);
      check($sformatf("fi_stall_%0d", k), {63'b0, fence_stall}, {63'b0, (k <= 7)});
      step();
    end
    // Re-arm via mem_advance, then a fresh request starts a second sequence
    release_mem();
    t = cyc;
    fence_i_req = 1'b1;
    dd_at = t + 2; id_at = t + 4;
    push_ev(t + 1, EV_DC, 1'b1, 1'b0, '0, '0);
    push_ev(t + 3, EV_IC, 1'b1, 1'b0, '0, '0);
    push_ev(t + 5, EV_DN, 1'b0, 1'b0, '0, '0);
    wait_cyc(t + 5);
    release_mem();

    // SFENCE.VMA: dtlb_done at +1, itlb_done at +4; operands change after accept
    t = cyc;
    sfence_req = 1'b1; sfence_asid = 9'h1A5; sfence_va = 32'h8000_1000;
    dt_at = t + 2; it_at = t + 5;
    push_ev(t + 1, EV_TLB, 1'b1, 1'b1, 9'h1A5, 32'h8000_1000);
    push_ev(t + 6, EV_DN, 1'b0, 1'b1, 9'h1A5, 32'h8000_1000);
    step();
    sfence_asid = 9'h0F0; sfence_va = 32'hDEAD_BEEF;
    wait_cyc(t + 6);
    release_mem();

    // Both fences at once; TLB dones arrive in the same cycle
    t = cyc;
    fence_i_req = 1'b1; sfence_req = 1'b1; sfence_asid = 9'h003; sfence_va = 32'h0000_0040;
    dd_at = t + 2; id_at = t + 4; it_at = t + 6; dt_at = t + 6;
    push_ev(t + 1, EV_DC, 1'b1, 1'b0, '0, '0);
    push_ev(t + 3, EV_IC, 1'b1, 1'b0, '0, '0);
    push_ev(t + 5, EV_TLB, 1'b1, 1'b1, 9'h003, 32'h0000_0040);
    push_ev(t + 7, EV_DN, 1'b0, 1'b1, 9'h003, 32'h0000_0040);
    wait_cyc(t + 7);
    release_mem();

    // Timeout: dflush_done only in the strobe cycle (ignored), so the phase is abandoned
    t = cyc;
    fence_i_req = 1'b1;
    dd_at = t + 1; id_at = t + 19;
    push_ev(t + 1,  EV_DC, 1'b1, 1'b0, '0, '0);
    push_ev(t + 16, EV_TO, 1'b1, 1'b0, '0, '0);
    push_ev(t + 17, EV_IC, 1'b1, 1'b0, '0, '0);
    push_ev(t + 20, EV_DN, 1'b0, 1'b0, '0, '0);
    wait_cyc(t + 20);
    release_mem();

    // No address translation: sfence completes the cycle after accept, no TLB strobes
    sfence_req_b = 1'b1;
    @(negedge CLK);
    check("noat_accept_stall", {62'b0, fence_stall_b, fence_done_b}, 64'd2);
    step();
    @(negedge CLK);
    check("noat_done", {58'b0, fence_stall_b, fence_done_b, itlb_fence_b, dtlb_fence_b,
          dcache_flush_b, fence_timeout_b}, 64'b010000);
    step();
    sfence_req_b = 1'b0; mem_advance_b = 1'b1;
    @(negedge CLK);
    check("noat_idle", {62'b0, fence_stall_b, fence_done_b}, 64'd0);
    step();
    mem_advance_b = 1'b0;

    // Reset during IFLUSH, late iflush_done ignored, next request restarts at DFLUSH
    t = cyc;
    fence_i_req = 1'b1;
    dd_at = t + 2; id_at = t + 6;
    push_ev(t + 1, EV_DC, 1'b1, 1'b0, '0, '0);
    push_ev(t + 3, EV_IC, 1'b1, 1'b0, '0, '0);
    wait_cyc(t + 4);
    nRST = 1'b0;
    fence_i_req = 1'b0;
    @(negedge CLK);
    check("midrst_outputs", {21'b0, fence_stall, dcache_flush, icache_flush, itlb_fence,
          dtlb_fence, fence_done, fence_timeout, fence_asid, fence_va}, 64'd0);
    step();
    nRST = 1'b1;
    wait_cyc(t + 7);
    fence_i_req = 1'b1;
    dd_at = t + 9; id_at = t + 11;
    push_ev(t + 8,  EV_DC, 1'b1, 1'b0, '0, '0);
    push_ev(t + 10, EV_IC, 1'b1, 1'b0, '0, '0);
    push_ev(t + 12, EV_DN, 1'b0, 1'b0, '0, '0);
    wait_cyc(t + 12);
    release_mem();

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) step();
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
